// File: rtl/encoder_emu_pkg.sv
// Shared types and helpers for the encoder emulator: step FSM states,
// quadrature phase encoding and the backlog saturation clamp.
package encoder_emu_pkg;

    localparam int ACC_W = 64;
    localparam int SUM_W = 66;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } step_state_t;

    // count[1:0] -> {a, b}; forward rotation makes A lead B
    function automatic logic [1:0] quad_enc(input logic [1:0] phase);
        logic [1:0] ab;
        case (phase)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b10;
            2'd2:    ab = 2'b11;
            default: ab = 2'b01;
        endcase
        return ab;
    endfunction

    function automatic logic signed [SUM_W-1:0] sat_clamp(
        input logic signed [SUM_W-1:0] raw,
        input logic signed [SUM_W-1:0] lim
    );
        logic signed [SUM_W-1:0] r;
        r = raw;
        if (raw > lim)
            r = lim;
        else if (raw < -lim)
            r = -lim;
        return r;
    endfunction

endpackage

// File: rtl/quad_step_engine.sv
// Rate-limited quadrature step FSM: consumes one backlog step at a time,
// wraps the position count and registers A/B/Z (Z only with ENC_INDEX_EN).
//
// state | meaning
// IDLE  | ready; steps immediately when a request is present
// HOLD  | enforcing minimum edge spacing, timer counting down to 0
module quad_step_engine
    import encoder_emu_pkg::*;
#(
    parameter int COUNTS_PER_REV = 4096,
    parameter int MIN_EDGE_CLKS  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        step_req,
    input  logic        step_dir,
    output logic        step_taken,
    output logic [31:0] count,
    output logic        a,
    output logic        b,
    output logic        z
);

    localparam int               TMR_W    = (MIN_EDGE_CLKS > 1) ? $clog2(MIN_EDGE_CLKS) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MIN_EDGE_CLKS - 1);
    localparam logic [31:0]      CNT_MAX  = 32'(COUNTS_PER_REV - 1);

    step_state_t      state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [31:0]      count_nxt;
    logic [1:0]       ab;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        count_nxt  = count;
        step_taken = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            timer_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (step_req) begin
                        step_taken = 1'b1;
                        if (step_dir)
                            count_nxt = (count == '0) ? CNT_MAX : count - 32'd1;
                        else
                            count_nxt = (count == CNT_MAX) ? '0 : count + 32'd1;
                        timer_nxt = TMR_LOAD;
                        state_nxt = (TMR_LOAD == '0) ? IDLE : HOLD;
                    end
                end
                HOLD: begin
                    timer_nxt = timer - 1'b1;
                    if (timer_nxt == '0)
                        state_nxt = IDLE;
                end
            endcase
        end
    end

    // Outputs follow the registered count one clock later
    assign ab = quad_enc(count[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a <= 1'b0;
            b <= 1'b0;
        end else begin
            a <= ab[1];
            b <= ab[0];
        end
    end

`ifdef ENC_INDEX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            z <= 1'b1;
        else
            z <= (count == '0);
    end
`else
    assign z = 1'b0;
`endif

endmodule

// File: rtl/encoder_emulator.sv
// Integrates solver speed into shaft position and drives quadrature A/B/Z.
// Index pulse Z is generated only when ENC_INDEX_EN is defined.
module encoder_emulator
    import encoder_emu_pkg::*;
#(
    parameter int FRAC_BITS      = 32,
    parameter int COUNTS_PER_REV = 4096,
    parameter int MIN_EDGE_CLKS  = 4,
    parameter int PEND_W         = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [63:0] speed,
    input  logic               speed_valid,
    input  logic               enable,
    input  logic               clr_overrun,
    output logic               a,
    output logic               b,
    output logic               z,
    output logic        [31:0] count,
    output logic               overrun
);

    localparam logic signed [SUM_W-1:0] MAX_PEND = SUM_W'((2 ** (PEND_W - 1)) - 1);

    logic signed [ACC_W-1:0]  acc, acc_new, delta;
    logic signed [PEND_W-1:0] pending;
    logic signed [SUM_W-1:0]  step_val, pend_raw, pend_clamped;
    logic                     integrate, sat_hit;
    logic                     step_req, step_dir, step_taken;

    assign integrate = speed_valid & enable;
    assign acc_new   = acc + speed;

    // Whole counts crossed by this update; 64-bit wrap keeps the difference exact
    always_comb begin
        delta = '0;
        if (integrate)
            delta = (acc_new >>> FRAC_BITS) - (acc >>> FRAC_BITS);
    end

    always_comb begin
        step_val = '0;
        if (step_taken)
            step_val = step_dir ? {SUM_W{1'b1}} : SUM_W'(1);
    end

    assign pend_raw     = SUM_W'(pending) - step_val + SUM_W'(delta);
    assign pend_clamped = sat_clamp(pend_raw, MAX_PEND);
    assign sat_hit      = (pend_clamped != pend_raw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            if (integrate)
                acc <= acc_new;
            if (!enable)
                pending <= '0;
            else
                pending <= pend_clamped[PEND_W-1:0];
            if (enable && sat_hit)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

    assign step_req = (pending != '0);
    assign step_dir = pending[PEND_W-1];

    quad_step_engine #(
        .COUNTS_PER_REV(COUNTS_PER_REV),
        .MIN_EDGE_CLKS (MIN_EDGE_CLKS)
    ) u_engine (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .step_req  (step_req),
        .step_dir  (step_dir),
        .step_taken(step_taken),
        .count     (count),
        .a         (a),
        .b         (b),
        .z         (z)
    );

endmodule

// File: tb/tb_encoder_emulator.sv
// Scoreboard bench for encoder_emulator: each strobe pushes the expected edges
// (cycle, count, A/B, Z); a negedge monitor pops and compares on every A/B edge.
`timescale 1ns/1ps
module tb_encoder_emulator;

    localparam int FRAC_BITS = 32;
    localparam int CPR       = 4096;
    localparam int MEC       = 4;
    // Narrow backlog keeps the saturation drain short
    localparam int PEND_W    = 12;
    localparam int MAX_PEND  = (2 ** (PEND_W - 1)) - 1;
`ifdef ENC_INDEX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [63:0] speed = '0;
    logic               speed_valid = 1'b0;
    logic               enable = 1'b0;
    logic               clr_overrun = 1'b0;
    logic               a, b, z, overrun;
    logic        [31:0] count;

    encoder_emulator #(
        .FRAC_BITS     (FRAC_BITS),
        .COUNTS_PER_REV(CPR),
        .MIN_EDGE_CLKS (MEC),
        .PEND_W        (PEND_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .speed      (speed),
        .speed_valid(speed_valid),
        .enable     (enable),
        .clr_overrun(clr_overrun),
        .a          (a),
        .b          (b),
        .z          (z),
        .count      (count),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         cnt;
        logic [1:0] ab;
        logic       z;
    } edge_t;

    edge_t              sb[$];
    edge_t              mon_e;
    int                 errors = 0;
    int                 checks = 0;
    int                 cyc = 0;
    bit                 mon_en = 1'b0;
    logic [1:0]         prev_ab = 2'b00;
    logic signed [63:0] acc_m = '0;
    int                 cnt_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] exp_ab(input int c);
        case (c % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int step_cnt(input int c, input bit rev);
        if (rev) return (c == 0) ? CPR - 1 : c - 1;
        return (c == CPR - 1) ? 0 : c + 1;
    endfunction

    always @(negedge clk) begin
        if (mon_en && ({a, b} !== prev_ab)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_edge: ab=%b count=%0d at cycle %0d, required no edge", {a, b}, count, cyc);
            end else begin
                mon_e = sb.pop_front();
                checks++;
                if (cyc !== mon_e.cyc) begin
                    errors++;
                    $display("FAIL edge_cycle: edge at cycle %0d, required %0d", cyc, mon_e.cyc);
                end
                checks++;
                if (count !== 32'(mon_e.cnt)) begin
                    errors++;
                    $display("FAIL edge_count: count=%0d, required %0d", count, mon_e.cnt);
                end
                checks++;
                if ({a, b} !== mon_e.ab) begin
                    errors++;
                    $display("FAIL edge_ab: ab=%b, required %b", {a, b}, mon_e.ab);
                end
                checks++;
                if (z !== mon_e.z) begin
                    errors++;
                    $display("FAIL edge_z: z=%b, required %b", z, mon_e.z);
                end
            end
        end
        prev_ab <= {a, b};
    end

    task automatic do_reset();
        mon_en = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        speed_valid = 1'b0;
        clr_overrun = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        acc_m = '0;
        cnt_m = 0;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    // Model assumes the backlog has drained before each strobe
    task automatic strobe(input logic signed [63:0] spd, input bit clr);
        logic signed [63:0] acc_new, delta;
        int    pend, s_cyc, n;
        edge_t e;
        @(negedge clk);
        speed = spd;
        speed_valid = 1'b1;
        clr_overrun = clr;
        s_cyc = cyc + 1;
        if (enable) begin
            acc_new = acc_m + spd;
            delta = (acc_new >>> FRAC_BITS) - (acc_m >>> FRAC_BITS);
            acc_m = acc_new;
            if (delta > MAX_PEND) pend = MAX_PEND;
            else if (delta < -MAX_PEND) pend = -MAX_PEND;
            else pend = int'(delta);
            n = (pend < 0) ? -pend : pend;
            for (int k = 0; k < n; k++) begin
                cnt_m = step_cnt(cnt_m, pend < 0);
                e.cyc = s_cyc + 2 + k * MEC;
                e.cnt = cnt_m;
                e.ab  = exp_ab(cnt_m);
                e.z   = IDX_EN && (cnt_m == 0);
                sb.push_back(e);
            end
        end
        @(negedge clk);
        speed_valid = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d edges outstanding after %0d cycles, required 0", sb.size(), budget);
            sb.delete();
        end
        repeat (MEC + 16) @(negedge clk);
    endtask

    task automatic wait_remaining(input int left, input int budget);
        int n = 0;
        while (sb.size() > left && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() > left) begin
            errors++;
            $display("FAIL burst_timeout: %0d edges outstanding, required %0d", sb.size(), left);
        end
    endtask

    task automatic check_outputs(input string tag, input int c, input logic [1:0] ab, input logic zz, input logic ov);
        checks++;
        if (count !== 32'(c)) begin
            errors++;
            $display("FAIL %s_count: count=%0d, required %0d", tag, count, c);
        end
        checks++;
        if ({a, b} !== ab) begin
            errors++;
            $display("FAIL %s_ab: ab=%b, required %b", tag, {a, b}, ab);
        end
        checks++;
        if (z !== zz) begin
            errors++;
            $display("FAIL %s_z: z=%b, required %b", tag, z, zz);
        end
        checks++;
        if (overrun !== ov) begin
            errors++;
            $display("FAIL %s_overrun: overrun=%b, required %b", tag, overrun, ov);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs("reset", 0, 2'b00, IDX_EN, 1'b0);
    endtask

    task automatic test_single_step();
        do_reset();
        strobe(64'sh0000_0001_0000_0000, 1'b0);
        wait_drain(50);
        check_outputs("single", 1, 2'b10, 1'b0, 1'b0);
    endtask

    task automatic test_fractional();
        do_reset();
        strobe(64'sh0000_0000_8000_0000, 1'b0);
        repeat (20) @(negedge clk);
        check_outputs("frac_half", 0, 2'b00, IDX_EN, 1'b0);
        strobe(64'sh0000_0000_8000_0000, 1'b0);
        wait_drain(50);
        check_outputs("frac_whole", 1, 2'b10, 1'b0, 1'b0);
    endtask

    task automatic test_burst();
        do_reset();
        strobe(64'sh0000_000A_0000_0000, 1'b0);
        wait_drain(100);
        check_outputs("burst", 10, 2'b11, 1'b0, 1'b0);
    endtask

    task automatic test_reverse_wrap();
        do_reset();
        strobe(64'shFFFF_FFFF_0000_0000, 1'b0);
        wait_drain(50);
        check_outputs("rev_wrap", CPR - 1, 2'b01, 1'b0, 1'b0);
        strobe(64'sh0000_0001_0000_0000, 1'b0);
        wait_drain(50);
        check_outputs("fwd_wrap", 0, 2'b00, IDX_EN, 1'b0);
    endtask

    task automatic test_saturation();
        do_reset();
        // clear in the same cycle as saturation: set must win
        strobe(64'sh0000_9C40_0000_0000, 1'b1);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL sat_set: overrun=%b, required 1", overrun);
        end
        wait_drain(MAX_PEND * MEC + 50);
        check_outputs("sat_drain", MAX_PEND, exp_ab(MAX_PEND), 1'b0, 1'b1);
        @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: overrun=%b, required 0", overrun);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit moved = 1'b0;
        do_reset();
        strobe(64'sh0000_0064_0000_0000, 1'b0);
        wait_remaining(95, 200);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_outputs("rst_mid", 0, 2'b00, IDX_EN, 1'b0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        acc_m = '0;
        cnt_m = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ({a, b} !== 2'b00 || count !== 32'd0) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL rst_backlog: outputs moved after reset, ab=%b count=%0d, required 00 and 0", {a, b}, count);
        end
    endtask

    task automatic test_enable_mid_burst();
        bit moved = 1'b0;
        do_reset();
        strobe(64'sh0000_0064_0000_0000, 1'b0);
        wait_remaining(95, 200);
        mon_en = 1'b0;
        enable = 1'b0;
        sb.delete();
        cnt_m = 5;
        // disabled strobe must not reach the accumulator
        strobe(64'sh0000_0000_8000_0000, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ({a, b} !== exp_ab(cnt_m) || count !== 32'(cnt_m)) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++;
            $display("FAIL en_hold: outputs moved while disabled, ab=%b count=%0d, required %b and %0d", {a, b}, count, exp_ab(cnt_m), cnt_m);
        end
        enable = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        strobe(64'sh0000_0000_8000_0000, 1'b0);
        repeat (40) @(negedge clk);
        check_outputs("en_cleared", 5, exp_ab(5), 1'b0, 1'b0);
        strobe(64'sh0000_0000_8000_0000, 1'b0);
        wait_drain(50);
        check_outputs("en_resume", 6, exp_ab(6), 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_fractional();
        test_burst();
        test_reverse_wrap();
        test_saturation();
        test_reset_mid_burst();
        test_enable_mid_burst();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/encoder_emulator.md
Name: encoder_emulator

Overview:
- Downstream consumer of solver_rk4_int speed output w. Integrates motor speed into shaft position and emits quadrature encoder signals A/B/Z plus a position count.
- Gives the AMDC encoder input path a hardware-in-the-loop source, so position/speed control loops close around the simulated motor.
- Sequential core: fractional phase accumulator, pending-step backlog counter, rate-limited quadrature step FSM.

Parameters:
- FRAC_BITS, 32, fractional bits of speed and accumulator; speed is signed Q(64-FRAC_BITS).FRAC_BITS in counts per update.
- COUNTS_PER_REV, 4096, quadrature counts per revolution; must be a multiple of 4.
- MIN_EDGE_CLKS, 4, minimum clk cycles between successive A/B edges; must be ≥1.
- PEND_W, 16, width of signed backlog; MAX_PEND = 2^(PEND_W-1)-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- speed  in  64  signed speed sample from solver w
- speed_valid  in  1  one-cycle strobe; speed is integrated once per strobe
- enable  in  1  high = emulator runs
- clr_overrun  in  1  one-cycle clear of the overrun flag
- a  out  1  quadrature channel A
- b  out  1  quadrature channel B
- z  out  1  index pulse
- count  out  32  position in counts, range 0..COUNTS_PER_REV-1
- overrun  out  1  sticky backlog-saturation flag

Behaviour:
- Reset: acc=0, pending=0, count=0, a=0, b=0, z=1, overrun=0, FSM=IDLE. Reset mid-burst drops the backlog immediately.
- Integrate: on speed_valid & enable, acc <= acc + speed (64-bit wrap).
  - delta = (acc_new >>> FRAC_BITS) - (acc_old >>> FRAC_BITS), computed signed in 64 bits.
  - delta is added to pending.
- Pending update per cycle: pending_next = pending - step_taken + delta.
  - Clamp to ±MAX_PEND. If clamping occurs, set overrun.
  - Simultaneous delta and step are both applied in the same cycle.
- FSM IDLE: if pending≠0:
  - Take one step in the direction of sign(pending): count ±1, wrapping modulo COUNTS_PER_REV (0-1 gives COUNTS_PER_REV-1).
  - Load timer = MIN_EDGE_CLKS-1.
  - Go to HOLD, or stay in IDLE if the timer load is 0.
- FSM HOLD: decrement the timer; at 0 return to IDLE.
  - With a continuous backlog, edges are exactly MIN_EDGE_CLKS clocks apart.
- Latency: the first A/B edge is registered on the 2nd rising clk after speed_valid is sampled.
- a/b are registered from count[1:0]: 0→(0,0), 1→(1,0), 2→(1,1), 3→(0,1). Forward means A leads B.
- z is registered (count==0); see the optional feature.
- enable low: acc frozen, pending cleared, FSM forced to IDLE, outputs hold their last values.
- overrun: set on saturation; cleared by clr_overrun. Set wins if both happen in the same cycle.

Optional Feature:
- Macro ENC_INDEX_EN.
- Defined: z behaves as above.
- Undefined: z tied to 0, including during reset, and the count==0 compare logic is omitted.

Decomposition:
- Package encoder_emu_pkg holds:
  - FSM state enum {IDLE, HOLD}
  - quad encoding function (count[1:0] → {a,b})
  - saturating-add helper for pending
- Sub-module quad_step_engine contains the FSM, timer, count wrap and A/B/Z registers. It takes a step request and direction, and returns step_taken.
- The top level keeps the accumulator, delta and pending logic.

Test Plan:
- Single step: speed=0x0000_0001_0000_0000 (1.0), one strobe → 2 clks later count=1, (a,b)=(1,0), z=0; nothing further.
- Fractional: speed=0x0000_0000_8000_0000 (0.5), two strobes → no edge after the 1st; one step after the 2nd; count=1.
- Burst spacing: speed=10.0, one strobe → 10 edges exactly 4 clks apart; final count=10, (a,b)=(1,1).
- Reverse wrap: from reset, speed=-1.0 strobe → count=4095, (a,b)=(0,1), z=0; then +1.0 strobe → count=0, (a,b)=(0,0), z=1.
- Saturation: speed=40000.0, one strobe → pending clamps to 32767, overrun=1; after draining, count=4095. Then clr_overrun → overrun=0.
- Reset/enable mid-burst: speed=100.0, deassert rst_n after 5 edges → all outputs at reset values at once, no further edges. Repeat with enable dropped → outputs hold, pending=0.
